// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2
  } lat_cls_e;

  localparam int CNT_W = 2;

  // Class 3 is reserved and behaves like a multiply.
  function automatic int lat_of(input logic [1:0] cls, input int alu_lat,
                                input int load_lat, input int mul_lat);
    int v;
    case (cls)
      LAT_ALU:  v = alu_lat;
      LAT_LOAD: v = load_lat;
      default:  v = mul_lat;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown entry: cycles left until the register's pending result is forwardable.
module hazard_sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // A new issue to this register replaces whatever is left of the older countdown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW/WAW hazard detector with per-register latency countdowns.
// Optional build macro HAZARD_SB_PERF_EN adds a free-running stall-cycle counter port.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int ALU_LAT    = 0,
  parameter int LOAD_LAT   = 1,
  parameter int MUL_LAT    = 3,
  parameter int CNT_W      = hazard_pkg::CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_rs_used,
  input  logic                  i_id_rt_used,
  input  logic                  i_id_wr_en,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic [1:0]            i_id_lat_cls,
  input  logic                  i_id_flush,
  output logic                  o_pc_stall,
  output logic                  o_if_id_stall,
  output logic                  o_control_mux,
  output logic [NUM_REGS-1:0]   o_busy_vec
`ifdef HAZARD_SB_PERF_EN
  ,
  output logic [31:0]           o_stall_cycles
`endif
);

  logic [CNT_W-1:0] w_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_lat;
  logic             w_raw;
  logic             w_waw;
  logic             w_stall;
  logic             w_issue;
  logic             w_rd_nz;

  // r0 is architecturally constant, so it never has a pending write.
  assign w_cnt[0]      = '0;
  assign o_busy_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      hazard_sb_entry #(.CNT_W(CNT_W)) u_entry (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_issue && (i_id_rd == REG_ADDR_W'(gi))),
        .i_load_val (w_lat),
        .o_cnt      (w_cnt[gi]),
        .o_busy     (o_busy_vec[gi])
      );
    end
  endgenerate

  assign w_lat   = CNT_W'(lat_of(i_id_lat_cls, ALU_LAT, LOAD_LAT, MUL_LAT));
  assign w_rd_nz = (i_id_rd != '0);

  // Hazard compare is purely combinational so the stall lands in the same cycle as ID.
  always_comb begin
    w_raw   = 1'b0;
    w_waw   = 1'b0;
    w_stall = 1'b0;
    w_issue = 1'b0;
    w_raw = i_id_valid &&
            ((i_id_rs_used && (w_cnt[i_id_rs] != '0)) ||
             (i_id_rt_used && (w_cnt[i_id_rt] != '0)));
    // A shorter-latency write behind a longer one would let the stale value land last.
    w_waw   = i_id_valid && i_id_wr_en && w_rd_nz && (w_cnt[i_id_rd] > w_lat);
    w_stall = (w_raw || w_waw) && !i_id_flush;
    w_issue = i_id_valid && !w_stall && !i_id_flush && i_id_wr_en && w_rd_nz;
  end

  assign o_pc_stall    = w_stall;
  assign o_if_id_stall = w_stall;
  assign o_control_mux = w_stall;

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] r_stall_cycles;

  // Counts stalled cycles; wraps naturally at the top of the 32-bit range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: stimulus pushes expectations, a negedge monitor checks them.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_wr_en;
  logic [4:0]  id_rd;
  logic [1:0]  id_lat_cls;
  logic        id_flush;
  logic        pc_stall;
  logic        if_id_stall;
  logic        control_mux;
  logic [31:0] busy_vec;
`ifdef HAZARD_SB_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];

  hazard_scoreboard dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_rs_used  (id_rs_used),
    .i_id_rt_used  (id_rt_used),
    .i_id_wr_en    (id_wr_en),
    .i_id_rd       (id_rd),
    .i_id_lat_cls  (id_lat_cls),
    .i_id_flush    (id_flush),
    .o_pc_stall    (pc_stall),
    .o_if_id_stall (if_id_stall),
    .o_control_mux (control_mux),
    .o_busy_vec    (busy_vec)
`ifdef HAZARD_SB_PERF_EN
    ,
    .o_stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every pushed cycle is checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if ({pc_stall, if_id_stall, control_mux} !== {3{e.stall}}) begin
          n_fail++;
          $display("FAIL %s stall: got pc=%b ifid=%b ctl=%b want %b",
                   e.name, pc_stall, if_id_stall, control_mux, e.stall);
        end
        n_tests++;
        if (busy_vec !== e.busy) begin
          n_fail++;
          $display("FAIL %s busy_vec: got %h want %h", e.name, busy_vec, e.busy);
        end
      end
    end
  end

  // One ID cycle: drive just after the edge, record what the monitor must see.
  task automatic step(input string nm, input logic rstn, input logic vld,
                      input logic rsu, input logic [4:0] rs,
                      input logic rtu, input logic [4:0] rt,
                      input logic wr, input logic [4:0] rd, input logic [1:0] cls,
                      input logic fl, input logic e_stall, input logic [31:0] e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rstn;
    id_valid   = vld;
    id_rs_used = rsu;
    id_rs      = rs;
    id_rt_used = rtu;
    id_rt      = rt;
    id_wr_en   = wr;
    id_rd      = rd;
    id_lat_cls = cls;
    id_flush   = fl;
    e.name  = nm;
    e.stall = e_stall;
    e.busy  = e_busy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [31:0] e_busy);
    step(nm, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, e_busy);
  endtask

  localparam logic [31:0] B5 = 32'h1 << 5;
  localparam logic [31:0] B8 = 32'h1 << 8;
  localparam logic [31:0] B9 = 32'h1 << 9;

  initial begin
    int guard;
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0;
    id_rt_used = 1'b0; id_wr_en = 1'b0; id_rd = '0; id_lat_cls = '0; id_flush = 1'b0;

    // Reset: consumer of r5 presented while held in reset must not stall.
    step("reset", 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 32'h0);

    // 1: load r5, add r6,r5,r7 -> one bubble, then issue.
    step("t1_load",    1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 32'h0);
    step("t1_use_stl", 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 2'd0, 1'b0, 1'b1, B5);
    step("t1_use_go",  1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 2'd0, 1'b0, 1'b0, 32'h0);
    idle("t1_idle", 32'h0);

    // 2: mul r8, consumer on rt -> exactly three stall cycles.
    step("t2_mul",  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd2, 1'b0, 1'b0, 32'h0);
    step("t2_stl3", 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 5'd10, 2'd0, 1'b0, 1'b1, B8);
    step("t2_stl2", 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 5'd10, 2'd0, 1'b0, 1'b1, B8);
    step("t2_stl1", 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 5'd10, 2'd0, 1'b0, 1'b1, B8);
    step("t2_go",   1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 5'd10, 2'd0, 1'b0, 1'b0, 32'h0);

    // 3: mul r9 then load r9 -> WAW stall until cnt<=1, load leaves cnt=1.
    step("t3_mul",  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 32'h0);
    step("t3_waw3", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd1, 1'b0, 1'b1, B9);
    step("t3_waw2", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd1, 1'b0, 1'b1, B9);
    step("t3_go",   1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0, B9);
    idle("t3_cnt1", B9);
    idle("t3_done", 32'h0);

    // 4: r0 never tracked; unused source ignored; flush drops stall and blocks issue.
    step("t4_ld_r0",  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 2'd1, 1'b0, 1'b0, 32'h0);
    step("t4_use_r0", 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 32'h0);
    step("t4_ld_r5",  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 32'h0);
    step("t4_unused", 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, B5);
    step("t4_ld_r5b", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 32'h0);
    step("t4_flush",  1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 2'd2, 1'b1, 1'b0, B5);
    idle("t4_noiss", 32'h0);

    // 5: reset while cnt[5]=2 with a consumer waiting.
    step("t5_mul5", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 32'h0);
    idle("t5_cnt3", B5);
    step("t5_rst",  1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 32'h0);
    step("t5_rel",  1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 32'h0);

    // 6: ten-cycle run containing four stall cycles.
    step("t6_mul8", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd2, 1'b0, 1'b0, 32'h0);
    step("t6_s1",   1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, B8);
    step("t6_s2",   1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, B8);
    step("t6_s3",   1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, B8);
    step("t6_go8",  1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 32'h0);
    step("t6_ld5",  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0, 32'h0);
    step("t6_s4",   1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, B5);
    step("t6_go5",  1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 32'h0);
    idle("t6_i1", 32'h0);
    idle("t6_i2", 32'h0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

`ifdef HAZARD_SB_PERF_EN
    n_tests++;
    if (stall_cycles !== 32'd4) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d want 4", stall_cycles);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
